button_bounce_gen: RTL

- Synthesizable bouncing-button emulator for the counter10000 bench and for hardware-in-loop checks.
- Takes a clean level-change request and drives a contact-bounce waveform on o_btn: pseudo-random toggles for a fixed window, then a stable target level.
- Drives the i_btn input of button_debounce, so the debouncer can be exercised on-board and in simulation with repeatable noise.

---
 rtl/button_bounce_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/button_bounce_gen.sv
// button_bounce_gen: emulates a bouncing push-button driven by a 16-bit Galois LFSR.
module button_bounce_gen #(
  parameter int          BOUNCE_CYCLES = 200,
  parameter int          HOLD_MIN      = 4,
  parameter int          SETTLE_CYCLES = 100,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_level,
  output logic       o_btn,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_toggle_cnt
);
  localparam int BW = BOUNCE_CYCLES > 1 ? $clog2(BOUNCE_CYCLES) : 1;
  localparam int HW = HOLD_MIN > 1 ? $clog2(HOLD_MIN) : 1;
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [15:0] SEED = LFSR_SEED == 16'h0 ? 16'hACE1 : LFSR_SEED;
  localparam logic [BW-1:0] B_LAST = BW'(BOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_MIN - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  // SAME is the unbusy cycle between latching an unchanged level and DONE
  typedef enum logic [2:0] {IDLE, SAME, BOUNCE, SETTLE, DONE} state_t;
  state_t        state;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_next;
  logic          target;
  logic          flip;
  logic [BW-1:0] bounce_cnt;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] settle_cnt;
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign flip      = hold_cnt == H_LAST && lfsr[0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lfsr         <= SEED;
      target       <= 1'b0;
      o_btn        <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_toggle_cnt <= 8'd0;
      bounce_cnt   <= '0;
      hold_cnt     <= '0;
      settle_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            target       <= i_level;
            o_toggle_cnt <= 8'd0;
            bounce_cnt   <= '0;
            hold_cnt     <= '0;
            state        <= i_level == o_btn ? SAME : BOUNCE;
            o_busy       <= i_level != o_btn;
          end
        end
        SAME: begin
          state  <= DONE;
          o_busy <= 1'b1;
          o_done <= 1'b1;
        end
        BOUNCE: begin
          lfsr       <= lfsr_next;
          bounce_cnt <= bounce_cnt + 1'b1;
          if (bounce_cnt == B_LAST) begin
            state      <= SETTLE;
            o_btn      <= target;
            settle_cnt <= '0;
          end else if (flip) begin
            o_btn    <= ~o_btn;
            hold_cnt <= '0;
            if (o_toggle_cnt != 8'hFF) o_toggle_cnt <= o_toggle_cnt + 8'd1;
          end else if (hold_cnt != H_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == S_LAST) begin
            state  <= DONE;
            o_done <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
